// File: rtl/reg_ram_seq.sv
// Two-port round-robin sequencer for a level-sensitive register RAM.
// Each access runs SETUP, STROBE and HOLD phases and ends with a one-cycle response.
module reg_ram_seq #(
    parameter int ADDR_W        = 2,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              rsp_valid,
    output logic              rsp_src,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(STROBE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              op_we_q, op_we_d;
    logic              src_q, src_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              en_q, en_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_src_q, rsp_src_d;
    logic              rsp_wr_q, rsp_wr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic idle;
    logic gnt_dbg;

    // last_q holds the previous winner (0=CPU, 1=debug); a tie goes to the other one
    assign idle          = (state_q == IDLE);
    assign gnt_dbg       = dbg_req_valid && (!cpu_req_valid || !last_q);
    assign cpu_req_ready = idle && cpu_req_valid && !gnt_dbg;
    assign dbg_req_ready = idle && gnt_dbg;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        op_we_d     = op_we_q;
        src_d       = src_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        en_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_src_d   = rsp_src_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_ready || dbg_req_ready) begin
                    state_d = SETUP;
                    en_d    = 1'b1;
                    last_d  = gnt_dbg;
                    src_d   = gnt_dbg;
                    op_we_d = gnt_dbg ? dbg_req_we : cpu_req_we;
                    addr_d  = gnt_dbg ? dbg_req_addr : cpu_req_addr;
                    wdata_d = gnt_dbg ? dbg_req_wdata : cpu_req_wdata;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 2'd0;
                en_d    = 1'b1;
                we_d    = op_we_q;
            end
            STROBE: begin
                en_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d     = HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_src_d   = src_q;
                    rsp_wr_d    = op_we_q;
                    rsp_data_d  = op_we_q ? wdata_q : ram_data_out;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    we_d  = op_we_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            last_q      <= 1'b1;
            op_we_q     <= 1'b0;
            src_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            op_we_q     <= op_we_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            en_q        <= en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign busy        = !idle;
    assign ram_address = addr_q;
    assign ram_data_in = wdata_q;
    assign ram_we      = we_q;
    assign ram_en      = en_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_src     = rsp_src_q;
    assign rsp_wr      = rsp_wr_q;
    assign rsp_data    = rsp_data_q;

endmodule
